// File: rtl/tiny_nn_host_drv_if.sv
// Host-side handshake bundle for tiny_nn_host_drv: job request, operand stream, results and status.
// master = host/test logic, slave = the driver.
interface tiny_nn_host_drv_if;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  job_count;
    logic        job_relu;
    logic [15:0] job_bias;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_data;
    logic        op_last;
    logic        res_valid;
    logic [15:0] res_data;
    logic        busy;
    logic        err_underrun;
    logic        err_cfg;

    modport master (
        output job_valid, job_count, job_relu, job_bias, op_valid, op_data, op_last,
        input  job_ready, op_ready, res_valid, res_data, busy, err_underrun, err_cfg
    );

    modport slave (
        input  job_valid, job_count, job_relu, job_bias, op_valid, op_data, op_last,
        output job_ready, op_ready, res_valid, res_data, busy, err_underrun, err_cfg
    );
endinterface

// File: rtl/tiny_nn_host_drv.sv
// Serialises accumulate jobs onto the tiny_nn 16-bit input bus and reassembles its byte-wide results,
// using a local mirror of the NN accumulate FSM to know when result bytes are valid.
module tiny_nn_host_drv #(
    parameter logic [15:0] IdleWord = 16'h0000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    tiny_nn_host_drv_if.slave        host,
    output logic [15:0]              nn_data_o,
    input  logic [7:0]               nn_data_i
);
    // Must track the values in tiny_nn_pkg.
    localparam logic [3:0]  CmdOpAccumulate = 4'h1;
    localparam logic [15:0] FPStdNaN        = 16'h7e00;

    typedef enum logic [2:0] {DIdle, DCmd, DBias, DStream, DLast, DDrain} drv_state_e;
    typedef enum logic [1:0] {MIdle, MBias, MExec, MEnd} mir_state_e;

    drv_state_e  d_state, d_next;
    mir_state_e  m_state, m_next;
    logic [15:0] nn_data_next, bias_q, res_q;
    logic [7:0]  m_cnt, m_cnt_next, m_start, m_start_next, lo_q;
    logic        lo_pend_q, cap_lo, strobe;
    logic        job_ready, job_fire, op_ready, op_is_nan;
    logic        underrun_next, cfg_next, underrun_q, cfg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_state    <= DIdle;
            nn_data_o  <= IdleWord;
            bias_q     <= '0;
            underrun_q <= 1'b0;
            cfg_q      <= 1'b0;
        end else begin
            d_state    <= d_next;
            nn_data_o  <= nn_data_next;
            underrun_q <= underrun_next;
            cfg_q      <= cfg_next;
            if (job_fire) bias_q <= host.job_bias;
        end
    end

    assign op_is_nan = (host.op_data == FPStdNaN);
    assign job_fire  = host.job_valid && job_ready;

    always_comb begin
        d_next = d_state;
        unique case (d_state)
            DIdle:         if (job_fire && (host.job_count != 8'd0)) d_next = DCmd;
            DCmd:          d_next = DBias;
            DBias, DStream: begin
                if (!host.op_valid || op_is_nan) d_next = DDrain;
                else if (host.op_last)           d_next = DLast;
                else                             d_next = DStream;
            end
            DLast:         d_next = DDrain;
            // Leave drain on the same edge the mirror returns to idle so both are ready together.
            DDrain:        if (m_next == MIdle) d_next = DIdle;
            default:       d_next = DIdle;
        endcase
    end

    always_comb begin
        job_ready     = (d_state == DIdle) && (m_state == MIdle);
        op_ready      = (d_state == DBias) || (d_state == DStream);
        nn_data_next  = nn_data_o;
        underrun_next = 1'b0;
        cfg_next      = 1'b0;
        unique case (d_state)
            DIdle: begin
                nn_data_next = IdleWord;
                if (job_fire) begin
                    if (host.job_count != 8'd0)
                        nn_data_next = {CmdOpAccumulate, 3'b000, host.job_relu, host.job_count};
                    else
                        cfg_next = 1'b1;
                end
            end
            DCmd:          nn_data_next = bias_q;
            DBias, DStream: begin
                if (host.op_valid) begin
                    nn_data_next = host.op_data;
                end else begin
                    nn_data_next  = FPStdNaN;
                    underrun_next = 1'b1;
                end
            end
            DLast:         nn_data_next = FPStdNaN;
            DDrain:        nn_data_next = IdleWord;
            default:       nn_data_next = IdleWord;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_state   <= MIdle;
            m_cnt     <= '0;
            m_start   <= '0;
            lo_q      <= '0;
            lo_pend_q <= 1'b0;
            res_q     <= '0;
        end else begin
            m_state   <= m_next;
            m_cnt     <= m_cnt_next;
            m_start   <= m_start_next;
            lo_pend_q <= cap_lo;
            if (cap_lo) lo_q  <= nn_data_i;
            if (strobe) res_q <= {nn_data_i, lo_q};
        end
    end

    // Mirror of the NN accumulate FSM, driven by the word the NN sees this cycle.
    always_comb begin
        m_next       = m_state;
        m_cnt_next   = m_cnt;
        m_start_next = m_start;
        unique case (m_state)
            MIdle: begin
                if (nn_data_o[15:12] == CmdOpAccumulate) begin
                    m_start_next = nn_data_o[7:0];
                    m_cnt_next   = 8'd1;
                    m_next       = MBias;
                end
            end
            MBias: m_next = MExec;
            MExec: begin
                if (m_cnt == 8'd0) begin
                    m_cnt_next = m_start;
                end else begin
                    m_cnt_next = m_cnt - 8'd1;
                    if (nn_data_o == FPStdNaN) begin
                        m_next     = MEnd;
                        m_cnt_next = 8'd2;
                    end
                end
            end
            MEnd: begin
                if (m_cnt == 8'd0) m_next = MIdle;
                else               m_cnt_next = m_cnt - 8'd1;
            end
            default: m_next = MIdle;
        endcase
    end

    always_comb begin
        cap_lo = ((m_state == MExec) && (m_cnt == m_start)) ||
                 ((m_state == MEnd)  && (m_cnt == 8'd1));
        strobe = lo_pend_q && !cap_lo &&
                 ((m_state == MExec) || ((m_state == MEnd) && (m_cnt == 8'd0)));
    end

    assign host.job_ready    = job_ready;
    assign host.op_ready     = op_ready;
    assign host.res_valid    = strobe;
    assign host.res_data     = strobe ? {nn_data_i, lo_q} : res_q;
    assign host.busy         = !((d_state == DIdle) && (m_state == MIdle));
    assign host.err_underrun = underrun_q;
    assign host.err_cfg      = cfg_q;
endmodule

// File: tb/tb_tiny_nn_host_drv.sv
// Randomised bench for tiny_nn_host_drv: drives jobs and a random NN byte stream, and predicts bus words,
// handshakes and result pairs from per-cycle offsets relative to the job's command word.
module tb_tiny_nn_host_drv;
    localparam logic [15:0] IdleWord        = 16'h0000;
    localparam logic [3:0]  CmdOpAccumulate = 4'h1;
    localparam logic [15:0] FPStdNaN        = 16'h7e00;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] nn_data_o;
    logic [7:0]  nn_data_i;

    tiny_nn_host_drv_if host_if();

    tiny_nn_host_drv #(.IdleWord(IdleWord)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .host      (host_if),
        .nn_data_o (nn_data_o),
        .nn_data_i (nn_data_i)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] obs_word[$];
    logic [15:0] obs_res[$];
    logic [7:0]  obs_byte[$];
    logic        obs_valid[$];
    logic        obs_under[$];
    logic        obs_jready[$];
    logic        obs_oready[$];
    logic        obs_busy[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Samples the current cycle at the falling edge, then steps to just after the next rising edge.
    task automatic nextCycle();
        @(negedge clk_i);
        obs_word.push_back(nn_data_o);
        obs_res.push_back(host_if.res_data);
        obs_byte.push_back(nn_data_i);
        obs_valid.push_back(host_if.res_valid);
        obs_under.push_back(host_if.err_underrun);
        obs_jready.push_back(host_if.job_ready);
        obs_oready.push_back(host_if.op_ready);
        obs_busy.push_back(host_if.busy);
        @(posedge clk_i);
        #1;
        nn_data_i = 8'($urandom);
    endtask

    // NN group counter value while the k-th word after the bias is on the bus.
    function automatic int cntAt(input int k, input int n);
        if (k == 0) return 1;
        if (k == 1) return 0;
        return n - ((k - 2) % (n + 1));
    endfunction

    task automatic startJob(input int n, input bit relu, input logic [15:0] bias);
        int waited = 0;
        while (!host_if.job_ready && waited < 100) begin
            nextCycle();
            waited++;
        end
        checkOutput("job_ready_before_start", 32'(host_if.job_ready), 32'd1);
        host_if.job_valid = 1'b1;
        host_if.job_count = 8'(n);
        host_if.job_relu  = relu;
        host_if.job_bias  = bias;
        nextCycle();
        host_if.job_valid = 1'b0;
    endtask

    // mode 0: op_last on final operand, 1: underrun after nops, 2: final operand is FPStdNaN.
    // Called in the cycle the command word is on the bus; returns in the cycle after the NN is idle again.
    task automatic applyStimulus(input int n, input bit relu, input logic [15:0] bias,
                                 input int nops_in, input int mode);
        logic [15:0] ops[$];
        logic [15:0] op, lastR;
        logic [7:0]  lo;
        bit          pend;
        int          nops, tj, lastReady;
        nops = nops_in;
        tj   = (mode == 2) ? nops + 1 : nops + 2;
        while (cntAt(tj - 2, n) == 0) begin
            nops++;
            tj++;
        end
        for (int i = 0; i < nops; i++) begin
            op = 16'($urandom);
            if (op == FPStdNaN) op = op ^ 16'h0001;
            if (mode == 2 && i == nops - 1) op = FPStdNaN;
            ops.push_back(op);
        end
        obs_word.delete(); obs_res.delete(); obs_byte.delete(); obs_valid.delete();
        obs_under.delete(); obs_jready.delete(); obs_oready.delete(); obs_busy.delete();

        for (int j = 0; j <= tj + 4; j++) begin
            if (j >= 1 && j <= nops) begin
                host_if.op_valid = 1'b1;
                host_if.op_data  = ops[j-1];
                host_if.op_last  = (mode == 0) && (j == nops);
            end else begin
                host_if.op_valid = 1'b0;
                host_if.op_data  = 16'($urandom);
                host_if.op_last  = 1'b0;
            end
            nextCycle();
        end
        host_if.op_valid = 1'b0;
        host_if.op_last  = 1'b0;

        lastReady = (mode == 1) ? nops + 1 : nops;
        pend  = 1'b0;
        lo    = '0;
        lastR = '0;
        for (int j = 0; j <= tj + 4; j++) begin
            logic [15:0] ew;
            bit          ev, capLo;
            ev    = 1'b0;
            capLo = 1'b0;
            if (j == 0)       ew = {CmdOpAccumulate, 3'b000, relu, 8'(n)};
            else if (j == 1)  ew = bias;
            else if (j < tj)  ew = ops[j-2];
            else if (j == tj) ew = FPStdNaN;
            else              ew = IdleWord;
            if (j >= 2 && j <= tj) begin
                if (cntAt(j - 2, n) == n) capLo = 1'b1;
                else if (pend)            ev = 1'b1;
            end else if (j == tj + 2) begin
                capLo = 1'b1;
            end else if (j == tj + 3 && pend) begin
                ev = 1'b1;
            end
            checkOutput($sformatf("word[%0d]", j), 32'(obs_word[j]), 32'(ew));
            checkOutput($sformatf("op_ready[%0d]", j), 32'(obs_oready[j]), 32'(j >= 1 && j <= lastReady));
            checkOutput($sformatf("underrun[%0d]", j), 32'(obs_under[j]), 32'(mode == 1 && j == tj));
            checkOutput($sformatf("job_ready[%0d]", j), 32'(obs_jready[j]), 32'(j == tj + 4));
            checkOutput($sformatf("busy[%0d]", j), 32'(obs_busy[j]), 32'(j < tj + 4));
            checkOutput($sformatf("res_valid[%0d]", j), 32'(obs_valid[j]), 32'(ev));
            if (ev) begin
                lastR = {obs_byte[j], lo};
                checkOutput($sformatf("res_data[%0d]", j), 32'(obs_res[j]), 32'(lastR));
            end
            if (capLo) lo = obs_byte[j];
            pend = capLo;
        end
        checkOutput("res_data_held", 32'(obs_res[tj+4]), 32'(lastR));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] biasA, biasB;
        int n, nops, mode;
        bit relu;
        host_if.job_valid = 1'b0;
        host_if.job_count = '0;
        host_if.job_relu  = 1'b0;
        host_if.job_bias  = '0;
        host_if.op_valid  = 1'b0;
        host_if.op_data   = '0;
        host_if.op_last   = 1'b0;
        nn_data_i         = '0;
        rst_ni            = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        $display("[TB] reset state");
        checkOutput("rst_nn_data", 32'(nn_data_o), 32'(IdleWord));
        checkOutput("rst_job_ready", 32'(host_if.job_ready), 32'd1);
        checkOutput("rst_res_valid", 32'(host_if.res_valid), 32'd0);
        checkOutput("rst_res_data", 32'(host_if.res_data), 32'd0);
        checkOutput("rst_busy", 32'(host_if.busy), 32'd0);
        checkOutput("rst_op_ready", 32'(host_if.op_ready), 32'd0);

        $display("[TB] basic job N=2 relu=1");
        startJob(2, 1'b1, 16'h3c00);
        applyStimulus(2, 1'b1, 16'h3c00, 6, 0);

        $display("[TB] operand underrun");
        biasA = 16'($urandom);
        startJob(3, 1'b0, biasA);
        applyStimulus(3, 1'b0, biasA, 2, 1);

        $display("[TB] back-to-back jobs with job_valid held");
        biasA = 16'($urandom);
        biasB = 16'($urandom);
        startJob(2, 1'b0, biasA);
        host_if.job_valid = 1'b1;
        host_if.job_count = 8'd1;
        host_if.job_relu  = 1'b1;
        host_if.job_bias  = biasB;
        applyStimulus(2, 1'b0, biasA, 4, 0);
        host_if.job_valid = 1'b0;
        applyStimulus(1, 1'b1, biasB, 5, 2);

        $display("[TB] zero-count job");
        host_if.job_valid = 1'b1;
        host_if.job_count = 8'd0;
        host_if.job_bias  = 16'($urandom);
        nextCycle();
        host_if.job_valid = 1'b0;
        checkOutput("cfg_err_pulse", 32'(host_if.err_cfg), 32'd1);
        checkOutput("cfg_nn_data", 32'(nn_data_o), 32'(IdleWord));
        checkOutput("cfg_busy", 32'(host_if.busy), 32'd0);
        nextCycle();
        checkOutput("cfg_err_clear", 32'(host_if.err_cfg), 32'd0);
        checkOutput("cfg_nn_data_after", 32'(nn_data_o), 32'(IdleWord));
        checkOutput("cfg_job_ready", 32'(host_if.job_ready), 32'd1);

        $display("[TB] reset during operand stream");
        startJob(3, 1'b0, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            host_if.op_valid = 1'b1;
            host_if.op_data  = 16'h0100 + 16'(i);
            nextCycle();
        end
        #2;
        rst_ni = 1'b0;
        #1;
        host_if.op_valid = 1'b0;
        checkOutput("midrst_nn_data", 32'(nn_data_o), 32'(IdleWord));
        checkOutput("midrst_res_valid", 32'(host_if.res_valid), 32'd0);
        checkOutput("midrst_res_data", 32'(host_if.res_data), 32'd0);
        checkOutput("midrst_busy", 32'(host_if.busy), 32'd0);
        checkOutput("midrst_op_ready", 32'(host_if.op_ready), 32'd0);
        checkOutput("midrst_job_ready", 32'(host_if.job_ready), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        startJob(2, 1'b1, 16'h4000);
        applyStimulus(2, 1'b1, 16'h4000, 5, 0);

        $display("[TB] randomised jobs");
        repeat (20) begin
            n     = $urandom_range(1, 5);
            relu  = 1'($urandom);
            biasA = 16'($urandom);
            nops  = $urandom_range(1, 12);
            mode  = $urandom_range(0, 2);
            startJob(n, relu, biasA);
            applyStimulus(n, relu, biasA, nops, mode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
